// File: rtl/ex_div_if.sv
// Handshake/operand bundle between the EX stage and the multi-cycle divider.
interface ex_div_if #(
    parameter int unsigned N_REG = 32
);
    logic               i_signed_div;
    logic [N_REG-1:0]   i_opdata1;
    logic [N_REG-1:0]   i_opdata2;
    logic               i_start;
    logic               i_annul;
    logic [2*N_REG-1:0] o_result;
    logic               o_ready;

    modport master (
        output i_signed_div, i_opdata1, i_opdata2, i_start, i_annul,
        input  o_result, o_ready
    );

    modport slave (
        input  i_signed_div, i_opdata1, i_opdata2, i_start, i_annul,
        output o_result, o_ready
    );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// result held as {remainder, quotient} until EX drops its request.
module ex_div #(
    parameter int unsigned N_REG = 32
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    ex_div_if.slave   div_io
);
    localparam int unsigned CNT_W = 6;
    localparam int unsigned RES_W = 2 * N_REG;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REG-1:0]   rem_q, rem_d;
    logic [N_REG-1:0]   quo_q, quo_d;
    logic [N_REG-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               ready_q, ready_d;

    // Operand magnitudes and sign bookkeeping for the signed case
    logic               op1_neg_c, op2_neg_c;
    logic [N_REG-1:0]   mag1_c, mag2_c;

    assign op1_neg_c = div_io.i_signed_div & div_io.i_opdata1[N_REG-1];
    assign op2_neg_c = div_io.i_signed_div & div_io.i_opdata2[N_REG-1];
    assign mag1_c    = op1_neg_c ? -div_io.i_opdata1 : div_io.i_opdata1;
    assign mag2_c    = op2_neg_c ? -div_io.i_opdata2 : div_io.i_opdata2;

    // One restoring step: bring in next dividend bit, try to subtract divisor
    logic [N_REG:0]     shift_c;
    logic [N_REG-1:0]   diff_c;
    logic               ge_c;

    assign shift_c = {rem_q, quo_q[N_REG-1]};
    assign ge_c    = (shift_c >= {1'b0, dvs_q});
    assign diff_c  = shift_c[N_REG-1:0] - dvs_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (div_io.i_start && !div_io.i_annul) begin
                    if (div_io.i_opdata2 == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = mag1_c;
                        dvs_d     = mag2_c;
                        neg_quo_d = op1_neg_c ^ op2_neg_c;
                        neg_rem_d = op1_neg_c;
                    end
                end
            end
            BYZERO: begin
                if (div_io.i_annul) begin
                    state_d = FREE;
                    ready_d = 1'b0;
                end else begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (div_io.i_annul) begin
                    state_d = FREE;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = '0;
                end else if (cnt_q < CNT_W'(N_REG)) begin
                    rem_d = ge_c ? diff_c : shift_c[N_REG-1:0];
                    quo_d = {quo_q[N_REG-2:0], ge_c};
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {(neg_rem_q ? -rem_q : rem_q),
                                (neg_quo_q ? -quo_q : quo_q)};
                    ready_d  = 1'b1;
                    state_d  = END;
                end
            end
            END: begin
                if (!div_io.i_start) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: begin
                state_d = FREE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign div_io.o_result = result_q;
    assign div_io.o_ready  = ready_q;
endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: latency, signed/unsigned results, divide by zero,
// annul, END hold/release and asynchronous reset.
module tb_ex_div;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ex_div_if #(.N_REG(32)) dif ();

    ex_div #(.N_REG(32)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .div_io (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dif.i_signed_div = sgn;
        dif.i_opdata1    = a;
        dif.i_opdata2    = b;
        dif.i_start      = 1'b1;
    endtask

    // Counts edges from the next one (the accepting edge is edge 1); 0 = timeout
    task automatic wait_ready(input int max_edges, output int edges);
        edges = 0;
        for (int i = 1; i <= max_edges; i++) begin
            @(posedge clk);
            #1;
            if (dif.o_ready === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic release_start();
        @(negedge clk);
        dif.i_start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dif.i_signed_div = 1'b0;
        dif.i_opdata1 = '0;
        dif.i_opdata2 = '0;
        dif.i_start = 1'b0;
        dif.i_annul = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dif.o_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", dif.o_ready);
        end
        n_checks++;
        if (dif.o_result !== 64'h0) begin
            n_fail++; $display("FAIL reset_result: got %h expected 0", dif.o_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        int e;
        drive(1'b0, 32'd100, 32'd7);
        wait_ready(40, e);
        n_checks++;
        if (e !== 34) begin
            n_fail++; $display("FAIL udiv_latency: got %0d expected 34", e);
        end
        n_checks++;
        if (dif.o_result !== 64'h00000002_0000000E) begin
            n_fail++; $display("FAIL udiv_result: got %h expected 000000020000000e", dif.o_result);
        end
        release_start();
    endtask

    task automatic test_signed();
        int e;
        drive(1'b1, 32'hFFFFFFF9, 32'h00000002);
        // Operands change right after acceptance and must be ignored
        @(posedge clk);
        @(negedge clk);
        dif.i_signed_div = 1'b0;
        dif.i_opdata1 = 32'h12345678;
        dif.i_opdata2 = 32'h0;
        wait_ready(40, e);
        n_checks++;
        if (e + 1 !== 34) begin
            n_fail++; $display("FAIL sdiv_latency: got %0d expected 34", e + 1);
        end
        n_checks++;
        if (dif.o_result !== 64'hFFFFFFFF_FFFFFFFD) begin
            n_fail++; $display("FAIL sdiv_neg7_2: got %h expected fffffffffffffffd", dif.o_result);
        end
        release_start();
        drive(1'b0, 32'hFFFFFFF9, 32'h00000002);
        wait_ready(40, e);
        n_checks++;
        if (dif.o_result !== 64'h00000001_7FFFFFFC) begin
            n_fail++; $display("FAIL udiv_fff9_2: got %h expected 000000017ffffffc", dif.o_result);
        end
        release_start();
        drive(1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_ready(40, e);
        n_checks++;
        if (dif.o_result !== 64'h00000000_80000000) begin
            n_fail++; $display("FAIL sdiv_overflow: got %h expected 0000000080000000", dif.o_result);
        end
        release_start();
        drive(1'b1, 32'd7, 32'hFFFFFFFE);
        wait_ready(40, e);
        n_checks++;
        if (dif.o_result !== 64'h00000001_FFFFFFFD) begin
            n_fail++; $display("FAIL sdiv_7_neg2: got %h expected 00000001fffffffd", dif.o_result);
        end
        release_start();
    endtask

    task automatic test_by_zero();
        int e;
        drive(1'b0, 32'd5, 32'd0);
        wait_ready(40, e);
        n_checks++;
        if (e !== 2) begin
            n_fail++; $display("FAIL div0_latency: got %0d expected 2", e);
        end
        n_checks++;
        if (dif.o_result !== 64'h0) begin
            n_fail++; $display("FAIL div0_result: got %h expected 0", dif.o_result);
        end
        release_start();
    endtask

    task automatic test_annul();
        int e;
        logic seen;
        drive(1'b0, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        @(negedge clk);
        dif.i_annul = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (dif.o_ready !== 1'b0) begin
            n_fail++; $display("FAIL annul_ready: got %b expected 0", dif.o_ready);
        end
        seen = 1'b0;
        // Annul held in FREE with start still high must block acceptance
        repeat (3) begin
            @(posedge clk); #1;
            if (dif.o_ready !== 1'b0) seen = 1'b1;
        end
        @(negedge clk);
        dif.i_annul = 1'b0;
        dif.i_start = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (dif.o_ready !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL annul_never_ready: got %b expected 0", seen);
        end
        drive(1'b0, 32'd9, 32'd3);
        wait_ready(40, e);
        n_checks++;
        if (e !== 34) begin
            n_fail++; $display("FAIL annul_restart_latency: got %0d expected 34", e);
        end
        n_checks++;
        if (dif.o_result !== 64'h00000000_00000003) begin
            n_fail++; $display("FAIL annul_restart_result: got %h expected 0000000000000003", dif.o_result);
        end
        release_start();
    endtask

    task automatic test_end_hold();
        int e;
        drive(1'b0, 32'd100, 32'd7);
        wait_ready(40, e);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (dif.o_ready !== 1'b1 || dif.o_result !== 64'h00000002_0000000E) begin
                n_fail++;
                $display("FAIL end_hold_%0d: got ready=%b result=%h expected ready=1 result=000000020000000e",
                         i, dif.o_ready, dif.o_result);
            end
        end
        release_start();
        n_checks++;
        if (dif.o_ready !== 1'b0 || dif.o_result !== 64'h0) begin
            n_fail++;
            $display("FAIL end_release: got ready=%b result=%h expected ready=0 result=0",
                     dif.o_ready, dif.o_result);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        drive(1'b0, 32'd100, 32'd7);
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dif.o_ready !== 1'b0 || dif.o_result !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid_on: got ready=%b result=%h expected 0/0", dif.o_ready, dif.o_result);
        end
        dif.i_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Reset while a result is held in END clears it before any edge
        drive(1'b0, 32'd9, 32'd3);
        wait_ready(40, e);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dif.o_ready !== 1'b0 || dif.o_result !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid_end: got ready=%b result=%h expected 0/0", dif.o_ready, dif.o_result);
        end
        dif.i_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'd100, 32'd7);
        wait_ready(40, e);
        n_checks++;
        if (e !== 34 || dif.o_result !== 64'h00000002_0000000E) begin
            n_fail++;
            $display("FAIL reset_recover: got edges=%0d result=%h expected 34 000000020000000e",
                     e, dif.o_result);
        end
        release_start();
    endtask

    task automatic test_back_to_back();
        int e;
        drive(1'b0, 32'hFFFFFFFF, 32'h00010000);
        wait_ready(40, e);
        n_checks++;
        if (dif.o_result !== 64'h0000FFFF_0000FFFF) begin
            n_fail++; $display("FAIL b2b_first: got %h expected 0000ffff0000ffff", dif.o_result);
        end
        release_start();
        drive(1'b1, 32'hFFFFFF9C, 32'd7);
        wait_ready(40, e);
        n_checks++;
        if (e !== 34 || dif.o_result !== 64'hFFFFFFFE_FFFFFFF2) begin
            n_fail++;
            $display("FAIL b2b_second: got edges=%0d result=%h expected 34 fffffffefffffff2",
                     e, dif.o_result);
        end
        release_start();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_by_zero();
        test_annul();
        test_end_hold();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
